// File: rtl/msx_pkg.sv
// Shared MSX cartridge definitions: mapper codes, opcode-scan states,
// the write-address table used to score mapper types, and score helpers.
package msx_pkg;

   typedef enum logic [2:0] {
      MAP_UNKNOWN = 3'd0,
      MAP_NONE    = 3'd1,
      MAP_GM2     = 3'd2,
      MAP_KONAMI  = 3'd3,
      MAP_SCC     = 3'd4,
      MAP_ASCII8  = 3'd5,
      MAP_ASCII16 = 3'd6
   } mapper_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OP   = 2'd1,
      S_LO   = 2'd2
   } opc_state_t;

   typedef enum logic {
      P_RUN    = 1'b0,
      P_DECIDE = 1'b1
   } phase_t;

   // Z80 "LD (nn),A": the bank-switch write we look for
   localparam logic [7:0] OPC_LD_NN_A = 8'h32;

   localparam logic [15:0] A_KON_4000 = 16'h4000;
   localparam logic [15:0] A_KON_8000 = 16'h8000;
   localparam logic [15:0] A_KON_A000 = 16'hA000;
   localparam logic [15:0] A_SCC_5000 = 16'h5000;
   localparam logic [15:0] A_SCC_9000 = 16'h9000;
   localparam logic [15:0] A_SCC_B000 = 16'hB000;
   localparam logic [15:0] A_A8_6800  = 16'h6800;
   localparam logic [15:0] A_A8_7800  = 16'h7800;
   localparam logic [15:0] A_A16_77FF = 16'h77FF;
   localparam logic [15:0] A_MIX_6000 = 16'h6000;
   localparam logic [15:0] A_MIX_7000 = 16'h7000;

   // images up to 64 KB fit the slot without a mapper
   localparam logic [26:0] NONE_MAX_SIZE = 27'h10000;

   typedef struct packed {
      logic scc;
      logic kon;
      logic a8;
      logic a16;
   } hit_t;

   typedef struct packed {
      logic [7:0] scc;
      logic [7:0] kon;
      logic [7:0] a8;
      logic [7:0] a16;
   } score_t;

   function automatic hit_t score_hit(input logic [15:0] a);
      hit_t h;
      h = '0;
      unique case (a)
         A_KON_4000, A_KON_8000, A_KON_A000: h.kon = 1'b1;
         A_SCC_5000, A_SCC_9000, A_SCC_B000: h.scc = 1'b1;
         A_A8_6800, A_A8_7800:               h.a8  = 1'b1;
         A_A16_77FF:                         h.a16 = 1'b1;
         A_MIX_6000: begin
            h.kon = 1'b1;
            h.a8  = 1'b1;
            h.a16 = 1'b1;
         end
         A_MIX_7000: begin
            h.scc = 1'b1;
            h.a8  = 1'b1;
            h.a16 = 1'b1;
         end
         default: h = '0;
      endcase
      return h;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c,
                                          input logic       en);
      return (en && c != 8'hFF) ? c + 8'd1 : c;
   endfunction

endpackage

// File: rtl/mapper_score_fsm.sv
// Opcode scanner: finds LD (nn),A in the byte stream and scores nn.
// Ports: clear (download start), accept/addr/data (byte), score (counters).
module mapper_score_fsm
   import msx_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        accept,
   input  logic [26:0] addr,
   input  logic [7:0]  data,
   output score_t      score
);

   opc_state_t  state_q, state_d;
   opc_state_t  st;
   logic [7:0]  lo_q, lo_d;
   logic [26:0] prev_q, prev_d;
   score_t      score_q, score_d;
   hit_t        hit;

   always_comb begin
      lo_d    = lo_q;
      prev_d  = prev_q;
      hit     = '0;
      score_d = clear ? '0 : score_q;
      // an address gap breaks any opcode in flight; the byte restarts
      // the scan from IDLE (a start-cycle byte does the same)
      st = state_q;
      if (clear || (accept && addr != prev_q + 27'd1)) begin
         st = S_IDLE;
      end
      state_d = st;
      if (accept) begin
         prev_d = addr;
         unique case (st)
            S_IDLE: begin
               if (data == OPC_LD_NN_A) state_d = S_OP;
            end
            S_OP: begin
               lo_d    = data;
               state_d = S_LO;
            end
            S_LO: begin
               hit         = score_hit({data, lo_q});
               score_d.scc = sat_inc(score_d.scc, hit.scc);
               score_d.kon = sat_inc(score_d.kon, hit.kon);
               score_d.a8  = sat_inc(score_d.a8, hit.a8);
               score_d.a16 = sat_inc(score_d.a16, hit.a16);
               state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         lo_q    <= '0;
         prev_q  <= '0;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         prev_q  <= prev_d;
         score_q <= score_d;
      end
   end

   assign score = score_q;

endmodule

// File: rtl/rom_mapper_detect.sv
// Guesses the MSX ROM mapper of a cartridge image while it downloads.
// Ports: clk, reset_n, rom_dl/ioctl_* (download), mapper/rom_size/valid/done.
module rom_mapper_detect
   import msx_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rom_dl,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [2:0]  mapper,
   output logic [26:0] rom_size,
   output logic        valid,
   output logic        done
);

   logic        rom_dl_q;
   phase_t      phase_q, phase_d;
   logic [26:0] size_q, size_d;
   mapper_t     mapper_q, mapper_d;
   logic [26:0] rom_size_q, rom_size_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;

   logic        start;
   logic        fall;
   logic        accept;
   logic [26:0] next_size;
   score_t      score;
   mapper_t     pick;
   logic [7:0]  best_cnt;

   assign start     = rom_dl & ~rom_dl_q;
   assign fall      = ~rom_dl & rom_dl_q;
   assign accept    = ioctl_wr & rom_dl;
   assign next_size = ioctl_addr + 27'd1;

   mapper_score_fsm u_score (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (start),
      .accept  (accept),
      .addr    (ioctl_addr),
      .data    (ioctl_dout),
      .score   (score)
   );

   // strict '>' keeps the earlier type on ties: SCC, Konami, ASCII8, ASCII16
   always_comb begin
      best_cnt = score.scc;
      pick     = MAP_SCC;
      if (score.kon > best_cnt) begin
         best_cnt = score.kon;
         pick     = MAP_KONAMI;
      end
      if (score.a8 > best_cnt) begin
         best_cnt = score.a8;
         pick     = MAP_ASCII8;
      end
      if (score.a16 > best_cnt) begin
         best_cnt = score.a16;
         pick     = MAP_ASCII16;
      end
      if (size_q <= NONE_MAX_SIZE) begin
         pick = MAP_NONE;
      end else if (best_cnt == 8'd0) begin
         pick = MAP_UNKNOWN;
      end
   end

   always_comb begin
      phase_d    = fall ? P_DECIDE : P_RUN;
      size_d     = start ? '0 : size_q;
      mapper_d   = mapper_q;
      rom_size_d = rom_size_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      if (accept && next_size > size_d) begin
         size_d = next_size;
      end
      // a new download arriving on the DECIDE cycle drops the decision
      if (start) begin
         valid_d = 1'b0;
      end else if (phase_q == P_DECIDE) begin
         mapper_d   = pick;
         rom_size_d = size_q;
         valid_d    = 1'b1;
         done_d     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_dl_q   <= 1'b0;
         phase_q    <= P_RUN;
         size_q     <= '0;
         mapper_q   <= MAP_UNKNOWN;
         rom_size_q <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rom_dl_q   <= rom_dl;
         phase_q    <= phase_d;
         size_q     <= size_d;
         mapper_q   <= mapper_d;
         rom_size_q <= rom_size_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
      end
   end

   assign mapper   = mapper_q;
   assign rom_size = rom_size_q;
   assign valid    = valid_q;
   assign done     = done_q;

endmodule

// File: tb/tb_rom_mapper_detect.sv
// Bench for rom_mapper_detect: directed downloads, pattern-scan model,
// per-cycle output compare plus literal pins.
module tb_rom_mapper_detect;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        rom_dl = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [26:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [2:0]  mapper;
   logic [26:0] rom_size;
   logic        valid;
   logic        done;

   rom_mapper_detect dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rom_dl     (rom_dl),
      .ioctl_wr   (ioctl_wr),
      .ioctl_addr (ioctl_addr),
      .ioctl_dout (ioctl_dout),
      .mapper     (mapper),
      .rom_size   (rom_size),
      .valid      (valid),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [26:0] a;
      logic [7:0]  d;
   } byte_t;

   byte_t       q[$];
   int          total = 0;
   int          bad = 0;
   logic        exp_valid = 1'b0;
   logic        exp_done = 1'b0;
   logic [2:0]  exp_mapper = 3'd0;
   logic [26:0] exp_size = '0;
   int          m_scc, m_kon, m_a8, m_a16;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("valid", {31'd0, valid}, {31'd0, exp_valid});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("mapper", {29'd0, mapper}, {29'd0, exp_mapper});
      chk("rom_size", {5'd0, rom_size}, {5'd0, exp_size});
   end

   function automatic void tally(input logic [15:0] a);
      case (a)
         16'h4000, 16'h8000, 16'hA000: m_kon++;
         16'h5000, 16'h9000, 16'hB000: m_scc++;
         16'h6800, 16'h7800: m_a8++;
         16'h77FF: m_a16++;
         16'h6000: begin m_kon++; m_a8++; m_a16++; end
         16'h7000: begin m_scc++; m_a8++; m_a16++; end
         default: ;
      endcase
   endfunction

   // scan the accepted stream for 0x32,lo,hi runs at consecutive addresses
   function automatic void model(output logic [2:0] m,
                                 output logic [26:0] s);
      int n, i, mx;
      int c[4];
      int code[4];
      n = q.size();
      m_scc = 0; m_kon = 0; m_a8 = 0; m_a16 = 0;
      s = '0;
      foreach (q[k]) if (q[k].a + 27'd1 > s) s = q[k].a + 27'd1;
      i = 0;
      while (i < n) begin
         if (q[i].d == 8'h32 && i + 1 < n && q[i+1].a == q[i].a + 27'd1) begin
            if (i + 2 < n && q[i+2].a == q[i+1].a + 27'd1) begin
               tally({q[i+2].d, q[i+1].d});
               i += 3;
            end else begin
               i += 2;
            end
         end else begin
            i += 1;
         end
      end
      if (m_scc > 255) m_scc = 255;
      if (m_kon > 255) m_kon = 255;
      if (m_a8 > 255) m_a8 = 255;
      if (m_a16 > 255) m_a16 = 255;
      c = '{m_scc, m_kon, m_a8, m_a16};
      code = '{4, 3, 5, 6};
      mx = 0;
      foreach (c[k]) if (c[k] > mx) mx = c[k];
      m = 3'd0;
      if (s <= 27'h10000) begin
         m = 3'd1;
      end else if (mx != 0) begin
         for (int k = 3; k >= 0; k--) if (c[k] == mx) m = 3'(code[k]);
      end
   endfunction

   task automatic start_dl();
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      rom_dl = 1'b1;
      q.delete();
      @(posedge clk); #1;
      exp_valid = 1'b0;
   endtask

   task automatic put(input logic [26:0] a, input logic [7:0] d);
      byte_t b;
      @(posedge clk); #1;
      ioctl_wr = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      b.a = a;
      b.d = d;
      q.push_back(b);
   endtask

   task automatic put3(input logic [26:0] a, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [7:0] d2);
      put(a, d0);
      put(a + 27'd1, d1);
      put(a + 27'd2, d2);
   endtask

   task automatic end_dl();
      logic [2:0]  m;
      logic [26:0] s;
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      rom_dl = 1'b0;
      model(m, s);
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_mapper = m;
      exp_size = s;
      exp_valid = 1'b1;
      exp_done = 1'b1;
      @(posedge clk); #1;
      exp_done = 1'b0;
   endtask

   task automatic end_and_restart();
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      rom_dl = 1'b0;
      @(posedge clk); #1;
      rom_dl = 1'b1;
      q.delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic pin(input string nm, input logic [2:0] m,
                      input logic [26:0] s);
      chk({nm, "_map"}, {29'd0, mapper}, {29'd0, m});
      chk({nm, "_size"}, {5'd0, rom_size}, {5'd0, s});
      chk({nm, "_model"}, {29'd0, exp_mapper}, {29'd0, m});
   endtask

   initial begin
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("rst_valid", {31'd0, valid}, 32'd0);

      start_dl();
      end_dl();
      pin("empty", 3'd1, 27'd0);

      start_dl();
      for (int a = 0; a < 32'h8000; a++) put(27'(a), 8'h00);
      end_dl();
      pin("plain32k", 3'd1, 27'h8000);
      chk("plain32k_valid", {31'd0, valid}, 32'd1);

      start_dl();
      put3(27'h100, 8'h32, 8'h00, 8'h50);
      put3(27'h103, 8'h32, 8'h00, 8'h90);
      put3(27'h106, 8'h32, 8'h00, 8'hB0);
      put(27'h1FFFF, 8'h00);
      end_dl();
      pin("scc", 3'd4, 27'h20000);
      chk("scc_cnt", 32'(m_scc), 32'd3);

      start_dl();
      put3(27'h200, 8'h32, 8'hFF, 8'h77);
      put3(27'h203, 8'h32, 8'hFF, 8'h77);
      put3(27'h206, 8'h32, 8'h00, 8'h60);
      put(27'h1FFFF, 8'h00);
      end_dl();
      pin("ascii16", 3'd6, 27'h20000);
      chk("a16_cnt", 32'(m_a16), 32'd3);

      start_dl();
      for (int i = 0; i < 300; i++) begin
         put3(27'h1000 + 27'(3 * i), 8'h32, 8'h00, 8'h80);
      end
      put(27'h1FFFF, 8'h00);
      end_dl();
      pin("kon_sat", 3'd3, 27'h20000);
      chk("kon_cnt", 32'(m_kon), 32'd255);

      start_dl();
      put(27'h300, 8'h32);
      put(27'h301, 8'h00);
      put(27'h305, 8'h70);
      put(27'h1FFFF, 8'h00);
      end_dl();
      pin("gap", 3'd0, 27'h20000);

      start_dl();
      put3(27'h100, 8'h32, 8'h00, 8'h70);
      put(27'hFFFF, 8'h00);
      end_dl();
      pin("size64k", 3'd1, 27'h10000);

      start_dl();
      put3(27'h100, 8'h32, 8'h00, 8'h70);
      put(27'h10000, 8'h00);
      end_dl();
      pin("tie", 3'd4, 27'h10001);

      start_dl();
      put3(27'h100, 8'h32, 8'h00, 8'h40);
      put(27'h1FFFF, 8'h00);
      end_and_restart();
      put3(27'h100, 8'h32, 8'h00, 8'h68);
      put(27'h1FFFF, 8'h00);
      end_dl();
      pin("abandon", 3'd5, 27'h20000);

      start_dl();
      put3(27'h100, 8'h32, 8'h00, 8'h80);
      put3(27'h103, 8'h32, 8'h00, 8'h80);
      put3(27'h106, 8'h32, 8'h00, 8'h80);
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      reset_n = 1'b0;
      q.delete();
      exp_mapper = 3'd0;
      exp_size = '0;
      exp_valid = 1'b0;
      #1;
      chk("rst_mid_map", {29'd0, mapper}, 32'd0);
      chk("rst_mid_size", {5'd0, rom_size}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      put3(27'h200, 8'h32, 8'h00, 8'hA0);
      put3(27'h203, 8'h32, 8'h00, 8'h50);
      put3(27'h206, 8'h32, 8'h00, 8'h50);
      put(27'h1FFFF, 8'h00);
      end_dl();
      pin("rst_mid", 3'd4, 27'h20000);
      chk("rst_mid_kon", 32'(m_kon), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rom_mapper_detect.md
ROM_MAPPER_DETECT -- requirements
Module: rom_mapper_detect

Interface
REQ-001 SHALL have port clk  input  1  system clock (clk_sys domain); all logic on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port rom_dl  input  1  high while a cartridge ROM download to this slot is active (ioctl_isROMA or ioctl_isROMB).
REQ-004 SHALL have port ioctl_wr  input  1  one-cycle strobe qualifying ioctl_addr and ioctl_dout.
REQ-005 SHALL have port ioctl_addr  input  27  byte address of the current download byte.
REQ-006 SHALL have port ioctl_dout  input  8  download data byte.
REQ-007 SHALL have port mapper  output  3  detected mapper: 0 Unknown, 1 None, 2 GM2, 3 Konami, 4 KonamiSCC, 5 ASCII8, 6 ASCII16.
REQ-008 SHALL have port rom_size  output  27  highest written address + 1 of the last download.
REQ-009 SHALL have port valid  output  1  high once a decision exists; low during a download.
REQ-010 SHALL have port done  output  1  one-cycle pulse when mapper and rom_size update.

Function
REQ-011 SHALL detect download start as the rising edge of rom_dl (registered compare): clear all four score counters and rom_size, force the opcode FSM to IDLE, and drive valid low.
REQ-012 SHALL process a byte only on cycles with ioctl_wr=1 and rom_dl=1; other writes are ignored.
REQ-013 SHALL update rom_size to ioctl_addr+1 on each accepted byte whose ioctl_addr+1 exceeds the current rom_size.
REQ-014 SHALL run an opcode FSM with states IDLE, OP, LO: IDLE goes to OP on byte 0x32; OP latches the byte as lo and goes to LO; LO forms addr={byte,lo}, scores it, and goes to IDLE.
REQ-015 SHALL return the FSM to IDLE without scoring when an accepted byte's ioctl_addr is not the previous accepted address +1; that byte is then evaluated from IDLE.
REQ-016 SHALL score as follows: 0x4000/0x8000/0xA000 Konami+1; 0x5000/0x9000/0xB000 SCC+1; 0x6800/0x7800 ASCII8+1; 0x77FF ASCII16+1; 0x6000 Konami, ASCII8 and ASCII16 +1 each; 0x7000 SCC, ASCII8 and ASCII16 +1 each; any other address scores nothing.
REQ-017 SHALL use 8-bit counters that saturate at 255 and do not wrap.
REQ-018 SHALL detect download end as the falling edge of rom_dl and enter DECIDE for exactly one cycle.
REQ-019 SHALL in DECIDE select 1 (None) if rom_size <= 0x10000; otherwise select the highest counter with tie priority SCC > Konami > ASCII8 > ASCII16; select 0 (Unknown) if all counters are 0.
REQ-020 SHALL never auto-select 2 (GM2); that code is reserved for manual selection upstream.
REQ-021 SHALL register mapper and rom_size, set valid=1 and pulse done in the cycle after DECIDE, giving 2 cycles of latency from the rom_dl falling edge to done.
REQ-022 SHALL hold mapper, rom_size and valid stable between decisions.
REQ-023 SHALL, when rom_dl rises in the same cycle as DECIDE, abandon that decision: no done pulse, and restart per REQ-011.
REQ-024 SHALL, when a download ends with zero accepted bytes, output mapper=1 and rom_size=0.

Reset
REQ-025 SHALL, while reset_n=0, drive mapper=0, rom_size=0, valid=0 and done=0, set the FSM to IDLE, clear the counters and clear the edge-detect register.
REQ-026 SHALL, when reset_n is asserted mid-download, discard all partial scores; after release, a still-high rom_dl is not treated as a new start, and the next falling edge decides using only the bytes received after reset.

Structure
REQ-027 SHALL define the mapper code enum (0..6) and the scoring address constants in a shared package (msx_pkg) used by msx1 and the OSD info path.
REQ-028 SHALL contain one sub-module, mapper_score_fsm (the opcode FSM plus counters); the decision and edge logic stay at the top level.

Verification
REQ-029 SHALL verify: 32 KB download, all bytes 0x00 -> done 2 cycles after rom_dl falls; mapper=1, rom_size=0x8000, valid=1.
REQ-030 SHALL verify: 128 KB with 0x32,0x00,0x50 / 0x32,0x00,0x90 / 0x32,0x00,0xB0 embedded -> SCC=3, mapper=4.
REQ-031 SHALL verify: 128 KB with 0x32,0xFF,0x77 twice and 0x32,0x00,0x60 once -> ASCII16=3, Konami=1, ASCII8=1 -> mapper=6.
REQ-032 SHALL verify: 128 KB with 300 copies of 0x32,0x00,0x80 -> Konami saturates at 255 -> mapper=3.
REQ-033 SHALL verify: 128 KB containing 0x32,0x00 at addresses N, N+1, then 0x70 at address N+5 -> no score (REQ-015) -> mapper=0.
REQ-034 SHALL verify: reset_n pulsed low mid-download of a Konami image -> outputs 0 at once; after the remaining bytes, the decision counts only post-reset opcodes.
